// File: rtl/phys_regfile_pkg.sv
// rtl/phys_regfile_pkg.sv - shared core sizing and types for the physical register file
package phys_regfile_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_PREGS = 64;
  localparam int PW        = $clog2(NUM_PREGS);

  typedef logic [PW-1:0]   preg_t;
  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/phys_regfile_if.sv
// rtl/phys_regfile_if.sv - write, allocate and read port bundle of the physical register file
interface phys_regfile_if #(
  parameter int XLEN      = phys_regfile_pkg::XLEN,
  parameter int NUM_PREGS = phys_regfile_pkg::NUM_PREGS,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 1
);
  localparam int PW = $clog2(NUM_PREGS);

  logic [NUM_WR-1:0]                  wr_en;
  logic [NUM_WR-1:0][PW-1:0]          wr_preg;
  logic [NUM_WR-1:0][XLEN-1:0]        wr_data;
  logic [NUM_ALLOC-1:0]               alloc_en;
  logic [NUM_ALLOC-1:0][PW-1:0]       alloc_preg;
  logic [NUM_RD-1:0][PW-1:0]          rd_preg;
  logic [NUM_RD-1:0][XLEN-1:0]        rd_data;
  logic [NUM_RD-1:0]                  rd_ready;

  modport master (
    output wr_en, wr_preg, wr_data, alloc_en, alloc_preg, rd_preg,
    input  rd_data, rd_ready
  );

  modport slave (
    input  wr_en, wr_preg, wr_data, alloc_en, alloc_preg, rd_preg,
    output rd_data, rd_ready
  );

endinterface

// File: rtl/prf_bypass.sv
// rtl/prf_bypass.sv - one read port: matches same-cycle writes and merges them over stored state
module prf_bypass #(
  parameter int XLEN   = 32,
  parameter int PW     = 6,
  parameter int NUM_WR = 2
) (
  input  logic [PW-1:0]               rd_preg,
  input  logic [XLEN-1:0]             stored_data,
  input  logic                        stored_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR-1:0][PW-1:0]   wr_preg,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data,
  output logic [XLEN-1:0]             rd_data,
  output logic                        rd_ready
);

  // Ascending scan so the highest-numbered matching write port is the one that sticks.
  always_comb begin
    rd_data  = stored_data;
    rd_ready = stored_ready;
    if (rd_preg != '0) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wr_preg[i] == rd_preg)) begin
          rd_data  = wr_data[i];
          rd_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phys_regfile.sv
// rtl/phys_regfile.sv - multi-ported physical register file with ready bits and write bypass
module phys_regfile #(
  parameter int XLEN      = phys_regfile_pkg::XLEN,
  parameter int NUM_PREGS = phys_regfile_pkg::NUM_PREGS,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 1
) (
  input  logic          clk,
  input  logic          rst,
  phys_regfile_if.slave prf
);
  localparam int PW = $clog2(NUM_PREGS);

  logic [XLEN-1:0]      mem [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready_q;

  // Preg 0 is never a write/alloc target, so its reset value (0, ready) holds forever.
  // Alloc clears are issued after the writes so alloc wins on the ready bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        mem[p] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (prf.wr_en[i] && (prf.wr_preg[i] != '0)) begin
          mem[prf.wr_preg[i]]     <= prf.wr_data[i];
          ready_q[prf.wr_preg[i]] <= 1'b1;
        end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (prf.alloc_en[j] && (prf.alloc_preg[j] != '0)) begin
          ready_q[prf.alloc_preg[j]] <= 1'b0;
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [PW-1:0]   sel;
    logic [XLEN-1:0] data;
    logic            rdy;

    assign sel = prf.rd_preg[r];

    prf_bypass #(
      .XLEN   (XLEN),
      .PW     (PW),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .rd_preg      (sel),
      .stored_data  (mem[sel]),
      .stored_ready (ready_q[sel]),
      .wr_en        (prf.wr_en),
      .wr_preg      (prf.wr_preg),
      .wr_data      (prf.wr_data),
      .rd_data      (data),
      .rd_ready     (rdy)
    );

    assign prf.rd_data[r]  = data;
    assign prf.rd_ready[r] = rdy;
  end

endmodule

// File: tb/tb_phys_regfile.sv
// tb/tb_phys_regfile.sv - scoreboard bench for phys_regfile against an array-based reference model
module tb_phys_regfile;
  import phys_regfile_pkg::*;

  localparam int NUM_RD    = 4;
  localparam int NUM_WR    = 2;
  localparam int NUM_ALLOC = 1;

  typedef struct {
    int    port;
    word_t data;
    logic  ready;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  phys_regfile_if bus ();

  phys_regfile u_dut (
    .clk (clk),
    .rst (rst),
    .prf (bus)
  );

  always #5 clk = ~clk;

  word_t m_data  [NUM_PREGS];
  bit    m_ready [NUM_PREGS];
  exp_t  sb_q [$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic clear_inputs();
    rst            = 1'b0;
    bus.wr_en      = '0;
    bus.wr_preg    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = '0;
    bus.alloc_preg = '0;
    bus.rd_preg    = '0;
  endtask

  task automatic read_all(input preg_t p);
    for (int r = 0; r < NUM_RD; r++) bus.rd_preg[r] = p;
  endtask

  function automatic exp_t expect_read(input int port);
    exp_t  e;
    preg_t p;
    p      = bus.rd_preg[port];
    e.port = port;
    if (p == 0) begin
      e.data  = '0;
      e.ready = 1'b1;
    end else begin
      e.data  = m_data[p];
      e.ready = m_ready[p];
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.wr_en[i] && bus.wr_preg[i] == p) begin
          e.data  = bus.wr_data[i];
          e.ready = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        m_data[p]  = '0;
        m_ready[p] = 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++)
        if (bus.wr_en[i] && bus.wr_preg[i] != 0) begin
          m_data[bus.wr_preg[i]]  = bus.wr_data[i];
          m_ready[bus.wr_preg[i]] = 1'b1;
        end
      for (int j = 0; j < NUM_ALLOC; j++)
        if (bus.alloc_en[j] && bus.alloc_preg[j] != 0)
          m_ready[bus.alloc_preg[j]] = 1'b0;
    end
  endtask

  // Inputs are stable from posedge+1; expectations pushed now are popped at the next negedge.
  task automatic step();
    if (!rst)
      for (int r = 0; r < NUM_RD; r++) sb_q.push_back(expect_read(r));
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_total++;
      if (bus.rd_data[e.port] === e.data && bus.rd_ready[e.port] === e.ready)
        n_pass++;
      else
        $display("FAIL rd_port%0d preg=%0d: got data=%h ready=%b, expected data=%h ready=%b",
                 e.port, bus.rd_preg[e.port], bus.rd_data[e.port], bus.rd_ready[e.port],
                 e.data, e.ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();

    // Post-reset read of 5; write to preg 0 is ignored
    clear_inputs();
    read_all(preg_t'(5));
    bus.wr_en[0] = 1'b1; bus.wr_preg[0] = preg_t'(0); bus.wr_data[0] = word_t'(32'hDEAD);
    bus.rd_preg[1] = preg_t'(0);
    step();
    clear_inputs();
    read_all(preg_t'(0));
    step();

    // Alloc 7, see not-ready, then bypass the producer write, then stored
    clear_inputs();
    bus.alloc_en[0] = 1'b1; bus.alloc_preg[0] = preg_t'(7);
    step();
    clear_inputs();
    read_all(preg_t'(7));
    step();
    clear_inputs();
    read_all(preg_t'(7));
    bus.wr_en[1] = 1'b1; bus.wr_preg[1] = preg_t'(7); bus.wr_data[1] = word_t'(32'h1234);
    step();
    clear_inputs();
    read_all(preg_t'(7));
    step();

    // Both write ports to preg 9: port 1 wins
    clear_inputs();
    read_all(preg_t'(9));
    bus.wr_en = '1;
    bus.wr_preg[0] = preg_t'(9); bus.wr_data[0] = word_t'(32'hA);
    bus.wr_preg[1] = preg_t'(9); bus.wr_data[1] = word_t'(32'hB);
    step();
    clear_inputs();
    read_all(preg_t'(9));
    step();

    // Alloc and write preg 12 together: data kept, ready cleared; same-cycle alloc not visible
    clear_inputs();
    read_all(preg_t'(12));
    bus.alloc_en[0] = 1'b1; bus.alloc_preg[0] = preg_t'(12);
    bus.wr_en[0] = 1'b1; bus.wr_preg[0] = preg_t'(12); bus.wr_data[0] = word_t'(32'h55);
    step();
    clear_inputs();
    read_all(preg_t'(12));
    step();

    // All read ports on preg 3 during its write
    clear_inputs();
    read_all(preg_t'(3));
    bus.wr_en[0] = 1'b1; bus.wr_preg[0] = preg_t'(3); bus.wr_data[0] = word_t'(32'h77);
    step();

    // Reset overrides a same-cycle write to preg 4
    clear_inputs();
    bus.wr_en[0] = 1'b1; bus.wr_preg[0] = preg_t'(4); bus.wr_data[0] = word_t'(32'h99);
    bus.alloc_en[0] = 1'b1; bus.alloc_preg[0] = preg_t'(4);
    rst = 1'b1;
    step();
    clear_inputs();
    read_all(preg_t'(4));
    bus.rd_preg[3] = preg_t'(3);
    step();

    // Random traffic over a small preg window to force collisions
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NUM_WR; i++) begin
        bus.wr_en[i]   = $urandom_range(0, 1) == 1;
        bus.wr_preg[i] = preg_t'($urandom_range(0, 15));
        bus.wr_data[i] = word_t'($urandom);
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        bus.alloc_en[j]   = $urandom_range(0, 2) == 0;
        bus.alloc_preg[j] = preg_t'($urandom_range(0, 15));
      end
      for (int r = 0; r < NUM_RD; r++)
        bus.rd_preg[r] = ($urandom_range(0, 3) == 0) ? bus.wr_preg[$urandom_range(0, NUM_WR - 1)]
                                                      : preg_t'($urandom_range(0, 15));
      step();
    end

    clear_inputs();
    @(negedge clk);
    #1;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/phys_regfile.md
PHYS_REGFILE -- requirements
Module: phys_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NUM_PREGS, default 64, physical register count (power of 2, >=32); PW = clog2(NUM_PREGS).
REQ-003 SHALL have parameter NUM_RD, default 4, read-port count.
REQ-004 SHALL have parameter NUM_WR, default 2, write-port count.
REQ-005 SHALL have parameter NUM_ALLOC, default 1, allocation-port count.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset: synchronous, active-high.
REQ-008 wr_en  input  [NUM_WR]  write strobe per write port.
REQ-009 wr_preg  input  [NUM_WR][PW]  destination physical register per write port.
REQ-010 wr_data  input  [NUM_WR][XLEN]  write data per write port.
REQ-011 alloc_en  input  [NUM_ALLOC]  rename allocated a new destination; clear its ready bit.
REQ-012 alloc_preg  input  [NUM_ALLOC][PW]  allocated physical register.
REQ-013 rd_preg  input  [NUM_RD][PW]  source physical register per read port.
REQ-014 rd_data  output  [NUM_RD][XLEN]  register value, combinational.
REQ-015 rd_ready  output  [NUM_RD]  value valid (producer has written), combinational.

Function
REQ-016 Storage: NUM_PREGS x XLEN data array plus NUM_PREGS ready bits, all flops.
REQ-017 Preg 0 SHALL read as 0 and ready=1 always; writes and allocs to preg 0 ignored.
REQ-018 Write: wr_en[i] with wr_preg[i]!=0 stores wr_data[i] and sets ready at the next edge.
REQ-019 Alloc: alloc_en[j] with alloc_preg[j]!=0 clears ready at the next edge; data unchanged.
REQ-020 Same-cycle alloc and write to one preg: data takes the write, ready ends 0 (alloc wins).
REQ-021 Multiple write ports to one preg in one cycle: highest port index wins data; ready set.
REQ-022 Read latency zero: rd_data/rd_ready reflect stored state plus same-cycle bypass.
REQ-023 Bypass: if any wr_en[i] matches rd_preg (nonzero), rd_data = that wr_data (highest index on tie), rd_ready=1.
REQ-024 Same-cycle alloc of the read preg SHALL NOT affect that cycle's rd_ready (takes effect next cycle).
REQ-025 Bypass SHALL apply independently to every read port; all read ports may name the same preg.
REQ-026 Out-of-range preg indices cannot occur (PW exact); no checking logic.

Reset
REQ-027 On rst all data entries SHALL become 0 and all ready bits 1 (initial mapping all valid).
REQ-028 rst SHALL override same-cycle writes and allocs; outputs during rst follow stored state plus bypass (don't-care to consumers).

Structure
REQ-029 XLEN, NUM_PREGS, PW and a preg_t typedef SHALL live in the shared core package.
REQ-030 One sub-module, prf_bypass (per read port: wr match, priority select, ready merge), instantiated NUM_RD times.

Verification
REQ-031 After reset, read preg 5 -> rd_data=0, rd_ready=1; preg 0 write 0xDEAD -> still reads 0.
REQ-032 alloc preg 7, next cycle read 7 -> rd_ready=0; write 0x1234 to 7 same cycle as read -> rd_data=0x1234, rd_ready=1; next cycle stored.
REQ-033 wr port0 and port1 both to preg 9 with 0xA and 0xB -> bypass and stored value 0xB.
REQ-034 alloc and write preg 12 (0x55) same cycle -> next cycle rd_data=0x55, rd_ready=0.
REQ-035 All 4 read ports on preg 3 while write 0x77 to 3 -> all ports 0x77, ready=1.
REQ-036 rst asserted with wr_en to preg 4 (0x99) -> preg 4 reads 0, ready=1 after reset.
